ysyx_23060072_dmem: RTL and testbench
=====================================

# ysyx_23060072_dmem

Single-port data-memory responder that serves load/store requests issued by the core's load-store unit over a valid/ready request channel and returns results on a valid/ready response channel. It performs byte-lane placement and byte-strobed writes internally, so the initiator never does read-modify-write. A programmable wait count emulates SRAM/bus latency. It sits between the LSU and the data address space in the RV32E pipeline.

## Interface
- BASE_ADDR, 32'h8000_0000, byte address of word 0
- DEPTH_WORDS, 1024, number of 32-bit words (power of two)
- LATENCY, 1, cycles from request accept to response valid (1..15)

- clk  input  1  clock, all state updates on posedge
- rst  input  1  synchronous active-high reset (one clock; reset is synchronous and active-high)
- req_valid_i  input  1  request present
- req_ready_o  output  1  responder can accept a request
- req_we_i  input  1  1 = store, 0 = load
- req_size_i  input  2  00 byte, 01 half, 10 word, 11 reserved
- req_addr_i  input  32  byte address
- req_wdata_i  input  32  store data, right-justified (byte in [7:0], half in [15:0])
- rsp_valid_o  output  1  response present
- rsp_ready_i  input  1  initiator accepts response
- rsp_rdata_o  output  32  raw aligned word for loads; 0 for stores and errors
- rsp_err_o  output  1  access fault

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready_o=1. Accept on req_valid_i & req_ready_o; capture we, size, addr, wdata. LATENCY=1 -> go to RESP directly; else load counter with LATENCY-1 and go to WAIT.
- WAIT: req_ready_o=0; counter decrements each cycle; at counter==1 -> RESP on next edge.
- Access commit happens on the edge entering RESP: word index = (addr-BASE_ADDR)>>2; offset = addr[1:0].
- Strobes: byte 4'b0001<<offset; half 4'b0011<<offset; word 4'b1111. Lane data = wdata<<(8*offset). Only strobed bytes are written.
- Loads: rsp_rdata_o = full stored word at index; LSU extracts and extends.
- Error (rsp_err_o=1, no write, rdata=0): addr < BASE_ADDR, index >= DEPTH_WORDS, or size==11.
- RESP: rsp_valid_o=1, outputs stable until rsp_ready_i; handshake edge -> IDLE.
- No request pipelining: next request is accepted no earlier than the cycle after the response handshake.

## Timing
- Reset: state IDLE, req_ready_o=1 after reset cycle (0 during rst), rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, counter 0. Memory contents not reset.
- Accept at edge E -> rsp_valid_o high after edge E+LATENCY-1 (LATENCY=1: cycle immediately after accept).
- Throughput: one transaction per LATENCY+1 cycles minimum with rsp_ready_i held 1.
- rst during WAIT: transaction dropped, no write committed. rst during RESP: write already committed, response dropped.
- req_valid_i while not ready: ignored; initiator must hold request.
- rsp_ready_i with rsp_valid_o=0: no effect.

## Configuration
- YSYX_23060072_DMEM_ALIGN_CHK_EN defined: half access with offset 2'b11 and word access with offset != 0 raise rsp_err_o=1, no write, rdata 0.
- Not defined: no alignment faults; strobes truncated to the addressed word (half at offset 3 writes only byte 3; word uses offset 0 placement, addr[1:0] ignored).

## Test plan
- Reset, store word 0xDEADBEEF at 0x8000_0010, load 0x8000_0010 -> rsp_rdata_o=0xDEADBEEF, err=0, rsp_valid one cycle after accept (LATENCY=1).
- Word 0x11223344 at 0x8000_0020, store byte 0xAA at 0x8000_0022, load -> 0x11AA3344; store half 0xBEEF at 0x8000_0020, load -> 0x11AABEEF.
- LATENCY=4, rsp_ready_i low 3 cycles: rsp_valid_o rises 4 cycles after accept, rdata stable while stalled, req_ready_o=0 throughout.
- Load 0x7FFF_FFFC and 0x8000_1000 (DEPTH 1024) -> err=1, rdata=0; prior contents unchanged.
- With ALIGN_CHK_EN: word store at 0x8000_0001 -> err=1, memory unchanged; without: word 0x8000_0001 writes 0x8000_0000, err=0.
- Assert rst in WAIT of a store (LATENCY=3) -> subsequent load of that address returns old value, rsp_valid_o=0 after reset.

Source files
------------

// File: rtl/ysyx_23060072_dmem.sv
// Single-port data memory responder with byte-lane placement and programmable response latency.
// Define YSYX_23060072_DMEM_ALIGN_CHK_EN to fault misaligned half/word accesses.
module ysyx_23060072_dmem #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);
    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        capture, commit;

    logic [31:0] mem [DEPTH_WORDS];

    // The access commits on the edge entering StResp; with LATENCY=1 that is the accept edge,
    // so the live request inputs are used instead of the captured copy.
    logic        cur_we;
    logic [1:0]  cur_size;
    logic [31:0] cur_addr, cur_wdata;
    logic [31:0] off_addr;
    logic [1:0]  lane;
    logic [IdxW-1:0] idx;
    logic [3:0]  strb;
    logic [31:0] lane_data;
    logic        range_err, size_err, align_err, acc_err;

    assign req_ready_o = (state_q == StIdle) && !rst;
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    assign cur_we    = (state_q == StIdle) ? req_we_i    : we_q;
    assign cur_size  = (state_q == StIdle) ? req_size_i  : size_q;
    assign cur_addr  = (state_q == StIdle) ? req_addr_i  : addr_q;
    assign cur_wdata = (state_q == StIdle) ? req_wdata_i : wdata_q;

    assign off_addr  = cur_addr - BASE_ADDR;
    assign lane      = cur_addr[1:0];
    assign idx       = IdxW'(off_addr >> 2);
    assign range_err = (cur_addr < BASE_ADDR) || ((off_addr >> 2) >= 32'(DEPTH_WORDS));
    assign acc_err   = range_err || size_err || align_err;

    always_comb begin
        strb      = 4'b0000;
        lane_data = cur_wdata;
        size_err  = 1'b0;
        align_err = 1'b0;
        case (cur_size)
            2'b00: begin
                strb      = 4'b0001 << lane;
                lane_data = cur_wdata << {lane, 3'b000};
            end
            2'b01: begin
                // Offset 3 truncates to byte 3 only when alignment checking is off.
                strb      = 4'b0011 << lane;
                lane_data = cur_wdata << {lane, 3'b000};
`ifdef YSYX_23060072_DMEM_ALIGN_CHK_EN
                align_err = (lane == 2'b11);
`endif
            end
            2'b10: begin
                strb = 4'b1111;
`ifdef YSYX_23060072_DMEM_ALIGN_CHK_EN
                align_err = (lane != 2'b00);
`endif
            end
            default: size_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        commit  = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid_i && req_ready_o) begin
                    capture = 1'b1;
                    if (LATENCY <= 1) begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                we_q    <= req_we_i;
                size_q  <= req_size_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end
            if (commit) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || cur_we) ? 32'h0 : mem[idx];
            end
        end
    end

    // Storage is not reset; a reset in the same cycle as the commit suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && commit && cur_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mem[idx][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ysyx_23060072_dmem.sv
// Scoreboard bench for ysyx_23060072_dmem: randomized loads/stores against a byte-level model.
module tb_ysyx_23060072_dmem;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 3;

    logic        clk, rst;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [31:0] rsp_rdata_o;

    ysyx_23060072_dmem #(
        .BASE_ADDR  (BASE),
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_we_i   (req_we_i),
        .req_size_i (req_size_i),
        .req_addr_i (req_addr_i),
        .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o  (rsp_err_o)
    );

    typedef struct {
        logic [31:0] rd;
        logic        er;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_q[$];
    logic [31:0] mm[int unsigned];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: memory as bytes; a store copies its N low bytes starting at the address offset,
    // dropping bytes that fall past the word. Words are placed at offset 0 unless checked.
    function automatic void model(input bit we, input logic [1:0] sz, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output bit er);
        int unsigned n, off, idx;
        logic [31:0] w;
        er = 0;
        rd = 32'h0;
        if (sz == 2'd3) er = 1;
        if (a < BASE || ((a - BASE) / 4) >= DEPTH) er = 1;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = a % 4;
`ifdef YSYX_23060072_DMEM_ALIGN_CHK_EN
        if ((sz == 2'd1 && off == 3) || (sz == 2'd2 && off != 0)) er = 1;
`endif
        if (sz == 2'd2) off = 0;
        if (er) return;
        idx = (a - BASE) / 4;
        if (!we) begin
            rd = mm[idx];
            return;
        end
        w = mm[idx];
        for (int k = 0; k < int'(n); k++) begin
            if (off + k < 4) w[8*(off+k) +: 8] = wd[8*k +: 8];
        end
        mm[idx] = w;
    endfunction

    task automatic do_req(input bit we, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input bit track);
        int n;
        exp_t e;
        bit er;
        @(negedge clk);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_size_i  = sz;
        req_addr_i  = a;
        req_wdata_i = wd;
        n = 0;
        while (!req_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_o) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout got ready=0 expected ready=1 addr %h", a);
            req_valid_i = 1'b0;
            return;
        end
        if (track) begin
            model(we, sz, a, wd, e.rd, er);
            e.er = er;
            exp_q.push_back(e);
            acc_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        req_wdata_i = $urandom;
        req_addr_i  = $urandom;
    endtask

    initial begin
        rsp_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1 rsp_ready_i = ($urandom_range(0, 2) != 0);
        end
    end

    bit          prev_valid = 0, prev_ready = 0;
    logic [31:0] held_rdata;
    logic        held_err;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 0;
        end else begin
            if (rsp_valid_o) begin
                check("ready_low_in_resp", {31'b0, req_ready_o}, 32'h0);
                if (!prev_valid) begin
                    if (acc_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp got valid=1 expected valid=0");
                    end else begin
                        check("latency", 32'(cyc), 32'(acc_q.pop_front() + int'(LAT) - 1));
                    end
                end else if (!prev_ready) begin
                    check("stall_rdata", rsp_rdata_o, held_rdata);
                    check("stall_err", {31'b0, rsp_err_o}, {31'b0, held_err});
                end
                if (rsp_ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_rsp got rdata %h expected no response", rsp_rdata_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_rdata", rsp_rdata_o, e.rd);
                        check("rsp_err", {31'b0, rsp_err_o}, {31'b0, e.er});
                    end
                end
            end
            prev_valid = rsp_valid_o;
            prev_ready = rsp_ready_i;
            held_rdata = rsp_rdata_o;
            held_err   = rsp_err_o;
        end
    end

    initial begin
        logic [31:0] a;
        int n;
        rst = 1'b1;
        req_valid_i = 1'b0;
        req_we_i = 1'b0;
        req_size_i = 2'd0;
        req_addr_i = 32'h0;
        req_wdata_i = 32'h0;
        repeat (3) @(negedge clk);
        check("ready_during_rst", {31'b0, req_ready_o}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_ready", {31'b0, req_ready_o}, 32'h1);
        check("reset_valid", {31'b0, rsp_valid_o}, 32'h0);
        check("reset_rdata", rsp_rdata_o, 32'h0);
        check("reset_err", {31'b0, rsp_err_o}, 32'h0);

        for (int i = 0; i < 16; i++) do_req(1, 2'd2, BASE + 32'(4 * i), $urandom, 1);

        do_req(1, 2'd2, 32'h8000_0010, 32'hDEAD_BEEF, 1);
        do_req(0, 2'd2, 32'h8000_0010, 32'h0, 1);
        do_req(1, 2'd2, 32'h8000_0020, 32'h1122_3344, 1);
        do_req(1, 2'd0, 32'h8000_0022, 32'hFFFF_FFAA, 1);
        do_req(0, 2'd2, 32'h8000_0020, 32'h0, 1);
        do_req(1, 2'd1, 32'h8000_0020, 32'h1234_BEEF, 1);
        do_req(0, 2'd2, 32'h8000_0020, 32'h0, 1);
        do_req(0, 2'd2, 32'h7FFF_FFFC, 32'h0, 1);
        do_req(0, 2'd2, 32'h8000_1000, 32'h0, 1);
        do_req(1, 2'd2, 32'h8000_1000, 32'h1111_1111, 1);
        do_req(1, 2'd3, 32'h8000_0020, 32'h2222_2222, 1);
        do_req(0, 2'd2, 32'h8000_0020, 32'h0, 1);
        do_req(1, 2'd2, 32'h8000_0001, 32'h5566_7788, 1);
        do_req(0, 2'd2, 32'h8000_0000, 32'h0, 1);
        do_req(1, 2'd1, 32'h8000_0007, 32'h0000_A5C3, 1);
        do_req(0, 2'd2, 32'h8000_0004, 32'h0, 1);

        // Drain, then reset while a store sits in the wait state.
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        do_req(1, 2'd2, 32'h8000_0014, 32'hCAFE_F00D, 0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("ready_in_rst", {31'b0, req_ready_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("valid_after_rst", {31'b0, rsp_valid_o}, 32'h0);
        check("ready_after_rst", {31'b0, req_ready_o}, 32'h1);
        do_req(0, 2'd2, 32'h8000_0014, 32'h0, 1);

        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 9))
                8: a = 32'h7FFF_FFFC - 32'($urandom_range(0, 3) * 4);
                9: a = BASE + 32'h1000 + 32'($urandom_range(0, 255));
                default: a = BASE + 32'($urandom_range(0, 63));
            endcase
            do_req($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), a, $urandom, 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
